// File: rtl/tile_pixel_walker_pkg.sv
// Shared fixed-point constants and types for the tile rasteriser back end.
// The same types are used by the setup stage upstream and the depth/colour stage downstream.
package tile_pixel_walker_pkg;
    localparam int TILE_WIDTH_BITS = 4;
    localparam int TILE_W          = 1 << TILE_WIDTH_BITS;
    localparam int FX_INT_BITS     = 12;
    localparam int FX_FRAC_BITS    = 4;
    localparam int FX_TOTAL_BITS   = FX_INT_BITS + FX_FRAC_BITS;
    localparam int EW              = FX_TOTAL_BITS * 2;
    localparam int COLOR_BITS      = 24;
    localparam int TILE_IDX_BITS   = FX_INT_BITS - TILE_WIDTH_BITS;
    localparam int FCNT_BITS       = 2 * TILE_WIDTH_BITS + 1;
    localparam int N_ACC           = 4;

    typedef struct packed {
        logic [FX_TOTAL_BITS-1:0] x;
        logic [FX_TOTAL_BITS-1:0] y;
        logic [FX_TOTAL_BITS-1:0] z;
    } coord_3d_t;

    typedef struct packed {
        logic [COLOR_BITS-1:0]    color;
        logic [TILE_IDX_BITS-1:0] tile_x;
        logic [TILE_IDX_BITS-1:0] tile_y;
    } metadata_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        CULL = 2'd2
    } walker_state_t;

    typedef struct packed {
        logic [FX_INT_BITS-1:0]   px;
        logic [FX_INT_BITS-1:0]   py;
        logic [FX_TOTAL_BITS-1:0] z;
        logic [COLOR_BITS-1:0]    color;
    } fragment_t;

    // 12.4 value sign-extended to accumulator width and scaled to 8 fractional bits.
    function automatic logic [EW-1:0] fx_to_acc(input logic [FX_TOTAL_BITS-1:0] v);
        return {{(EW - FX_TOTAL_BITS - FX_FRAC_BITS){v[FX_TOTAL_BITS-1]}}, v, {FX_FRAC_BITS{1'b0}}};
    endfunction
endpackage

// File: rtl/tile_pixel_walker_edge_stepper.sv
// One incremental accumulator: a row-start register and a current register.
// Used for the three edge functions and for depth.
module edge_stepper
    import tile_pixel_walker_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [EW-1:0] init_i,
    input  logic          step_x_i,
    input  logic          step_y_i,
    input  logic [EW-1:0] inc_x_i,
    input  logic [EW-1:0] inc_y_i,
    output logic [EW-1:0] cur_o
);
    logic [EW-1:0] row_q, row_d;
    logic [EW-1:0] cur_q, cur_d;

    always_comb begin
        row_d = row_q;
        cur_d = cur_q;
        if (load_i) begin
            row_d = init_i;
            cur_d = init_i;
        end else if (step_y_i) begin
            // New row starts from the stepped row value, not from the current value.
            row_d = row_q + inc_y_i;
            cur_d = row_q + inc_y_i;
        end else if (step_x_i) begin
            cur_d = cur_q + inc_x_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            cur_q <= '0;
        end else begin
            row_q <= row_d;
            cur_q <= cur_d;
        end
    end

    assign cur_o = cur_q;
endmodule

// File: rtl/tile_pixel_walker.sv
// Walks one tile in raster order, one pixel per cycle, emitting covered fragments.
// States: IDLE waits for a bundle | WALK rasters the tile | CULL one-cycle done pulse.
module tile_pixel_walker
    import tile_pixel_walker_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vld_in,
    output logic                     rdy_in,
    input  coord_3d_t                in_abs_pos,
    input  coord_3d_t                in_delta_0,
    input  coord_3d_t                in_delta_1,
    input  coord_3d_t                in_delta_2,
    input  logic signed [EW-1:0]     in_edge_0,
    input  logic signed [EW-1:0]     in_edge_1,
    input  logic signed [EW-1:0]     in_edge_2,
    input  logic signed [FX_TOTAL_BITS-1:0] in_dzdx,
    input  logic signed [FX_TOTAL_BITS-1:0] in_dzdy,
    input  logic signed [EW-1:0]     in_z_current,
    input  metadata_t                in_metadata,
    output logic                     vld_out,
    input  logic                     rdy_out,
    output logic [FX_INT_BITS-1:0]   out_px,
    output logic [FX_INT_BITS-1:0]   out_py,
    output logic [FX_TOTAL_BITS-1:0] out_z,
    output logic [COLOR_BITS-1:0]    out_color,
    output logic                     tile_done,
    output logic [FCNT_BITS-1:0]     frag_count
);
    walker_state_t              state_q, state_d;
    logic [TILE_WIDTH_BITS-1:0] cx_q, cx_d, cy_q, cy_d;
    fragment_t                  frag_q, frag_d;
    logic                       vld_q, vld_d;
    logic                       done_q, done_d;
    logic [FCNT_BITS-1:0]       fcnt_q, fcnt_d;
    metadata_t                  meta_q, meta_d;
    logic [EW-1:0]              inc_x_q [N_ACC];
    logic [EW-1:0]              inc_x_d [N_ACC];
    logic [EW-1:0]              inc_y_q [N_ACC];
    logic [EW-1:0]              inc_y_d [N_ACC];
    logic [EW-1:0]              acc_init [N_ACC];
    logic [EW-1:0]              acc_cur [N_ACC];
    logic [EW+1:0]              edge_sum;
    logic accept, cull, advance, walk_adv, row_end, last_px, covered, step_x, step_y;
    logic unused_bits;

    assign edge_sum = {{2{in_edge_0[EW-1]}}, in_edge_0}
                    + {{2{in_edge_1[EW-1]}}, in_edge_1}
                    + {{2{in_edge_2[EW-1]}}, in_edge_2};
    // Non-negative area sum means back-facing or degenerate.
    assign cull     = ~edge_sum[EW+1];
    assign accept   = vld_in && rdy_in;
    assign advance  = !vld_q || rdy_out;
    assign walk_adv = (state_q == WALK) && advance;
    assign row_end  = (cx_q == TILE_WIDTH_BITS'(TILE_W - 1));
    assign last_px  = row_end && (cy_q == TILE_WIDTH_BITS'(TILE_W - 1));
    assign step_x   = walk_adv && !row_end;
    assign step_y   = walk_adv && row_end;
    assign covered  = (acc_cur[0][EW-1] || (acc_cur[0] == '0))
                   && (acc_cur[1][EW-1] || (acc_cur[1] == '0))
                   && (acc_cur[2][EW-1] || (acc_cur[2] == '0));

    assign acc_init[0] = in_edge_0;
    assign acc_init[1] = in_edge_1;
    assign acc_init[2] = in_edge_2;
    assign acc_init[3] = in_z_current;

    for (genvar i = 0; i < N_ACC; i++) begin : g_acc
        edge_stepper u_step (
            .clk      (clk),
            .rst      (rst),
            .load_i   (accept),
            .init_i   (acc_init[i]),
            .step_x_i (step_x),
            .step_y_i (step_y),
            .inc_x_i  (inc_x_q[i]),
            .inc_y_i  (inc_y_q[i]),
            .cur_o    (acc_cur[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (vld_in) state_d = cull ? CULL : WALK;
            WALK:    if (advance && last_px) state_d = IDLE;
            CULL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdy_in     = (state_q == IDLE);
        vld_out    = vld_q;
        out_px     = frag_q.px;
        out_py     = frag_q.py;
        out_z      = frag_q.z;
        out_color  = frag_q.color;
        tile_done  = done_q;
        frag_count = fcnt_q;
    end

    always_comb begin
        cx_d    = cx_q;
        cy_d    = cy_q;
        frag_d  = frag_q;
        vld_d   = vld_q;
        done_d  = 1'b0;
        fcnt_d  = fcnt_q;
        meta_d  = meta_q;
        inc_x_d = inc_x_q;
        inc_y_d = inc_y_q;
        if (accept) begin
            meta_d     = in_metadata;
            cx_d       = '0;
            cy_d       = '0;
            fcnt_d     = '0;
            done_d     = cull;
            inc_x_d[0] = fx_to_acc(in_delta_0.y);
            inc_x_d[1] = fx_to_acc(in_delta_1.y);
            inc_x_d[2] = fx_to_acc(in_delta_2.y);
            inc_x_d[3] = fx_to_acc(in_dzdx);
            inc_y_d[0] = -fx_to_acc(in_delta_0.x);
            inc_y_d[1] = -fx_to_acc(in_delta_1.x);
            inc_y_d[2] = -fx_to_acc(in_delta_2.x);
            inc_y_d[3] = fx_to_acc(in_dzdy);
        end
        if (walk_adv) begin
            if (covered) begin
                frag_d.px    = {meta_q.tile_x, cx_q};
                frag_d.py    = {meta_q.tile_y, cy_q};
                frag_d.z     = acc_cur[3][FX_TOTAL_BITS-1+FX_FRAC_BITS:FX_FRAC_BITS];
                frag_d.color = meta_q.color;
                vld_d        = 1'b1;
                fcnt_d       = fcnt_q + 1'b1;
            end else begin
                vld_d = 1'b0;
            end
            cx_d = cx_q + 1'b1;
            if (row_end) cy_d = cy_q + 1'b1;
            done_d = last_px;
        end else if (state_q != WALK && rdy_out) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cx_q   <= '0;
            cy_q   <= '0;
            frag_q <= '0;
            vld_q  <= 1'b0;
            done_q <= 1'b0;
            fcnt_q <= '0;
            meta_q <= '0;
            for (int i = 0; i < N_ACC; i++) begin
                inc_x_q[i] <= '0;
                inc_y_q[i] <= '0;
            end
        end else begin
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            frag_q  <= frag_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            fcnt_q  <= fcnt_d;
            meta_q  <= meta_d;
            inc_x_q <= inc_x_d;
            inc_y_q <= inc_y_d;
        end
    end

    // Tile origin and delta z come from the setup stage but are not needed here.
    assign unused_bits = ^{in_abs_pos, in_delta_0.z, in_delta_1.z, in_delta_2.z,
                           acc_cur[3], edge_sum};
endmodule
